// File: rtl/jk_excitation_seq.sv
// W-bit JK-flip-flop state register driven by a JK excitation generator (LOAD jumps, WALK counts up).
// Latency: LOAD accept->q at +1 edge, done at +1, ready at +2; WALK takes (target-q) mod 2^W excitation edges.
// Backpressure: tgt_ready low outside IDLE; requests seen then are ignored and must be held by the requester.
module jk_excitation_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic         tgt_op,
    input  logic [W-1:0] tgt_data,
    output logic [W-1:0] q,
    output logic [W-1:0] j_out,
    output logic [W-1:0] k_out,
    output logic         done,
    output logic [W-1:0] step_count
);

    typedef enum logic [1:0] {IDLE, EXCITE, DONE} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] tgt_q;
    logic         op_q;
    logic [W-1:0] n_want;
    logic [W-1:0] q_nxt;
    logic         accept;

    always_comb begin
        state_nxt = state;
        tgt_ready = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        n_want    = q;
        j_out     = '0;
        k_out     = '0;
        case (state)
            IDLE: begin
                tgt_ready = 1'b1;
                if (tgt_valid) begin
                    accept = 1'b1;
                    // A WALK that is already at its target needs no excitation edge.
                    state_nxt = (tgt_op && (tgt_data == q)) ? DONE : EXCITE;
                end
            end
            EXCITE: begin
                n_want = op_q ? (q + W'(1)) : tgt_q;
                j_out  = ~q & n_want;
                k_out  = q & ~n_want;
                if (!op_q || (n_want == tgt_q)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-bit JK cells; outside EXCITE J=K=0 so every cell holds.
    for (genvar i = 0; i < W; i++) begin : g_cell
        assign q_nxt[i] = (j_out[i] & ~q[i]) | (~k_out[i] & q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            q          <= '0;
            tgt_q      <= '0;
            op_q       <= 1'b0;
            step_count <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            if (accept) begin
                tgt_q      <= tgt_data;
                op_q       <= tgt_op;
                step_count <= '0;
            end else if (state == EXCITE) begin
                step_count <= step_count + W'(1);
            end
        end
    end

endmodule

// File: doc/jk_excitation_seq.md
Name: jk_excitation_seq

Overview:
- W-bit state register built from JK flip-flop cells, driven by an excitation generator.
- The generator takes a desired next state and produces the per-bit J/K inputs that reach it (JK excitation table).
- It is the inverse of our SR-to-JK conversion path: it starts from the required state transition and works back to the flip-flop inputs.
- Used as the sequencing engine for converter demos and the FF-conversion verification benches.

Parameters:
- W, 4, width of state register, target word and step counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- tgt_valid  input  1  request valid.
- tgt_ready  output  1  block idle and able to accept a request.
- tgt_op  input  1  0 = LOAD (jump to target in one edge), 1 = WALK (count up to target).
- tgt_data  input  W  target state.
- q  output  W  current JK register state.
- j_out  output  W  J inputs applied at the coming edge (combinational).
- k_out  output  W  K inputs applied at the coming edge (combinational).
- done  output  1  one-cycle completion pulse.
- step_count  output  W  number of excitation edges used by the last request; held until the next accept.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; q=0, step_count=0, done=0, tgt_ready=1.
  - j_out=0, k_out=0.
  - Latched target and op cleared.
  - Reset mid-operation abandons the request immediately with no done pulse.
- JK cell: q_next[i] = (j[i] & ~q[i]) | (~k[i] & q[i]).
  - The cell is implemented per bit and must not be replaced by direct assignment of q.
- Excitation per bit, from current q and desired next n; don't-cares are driven 0:
  - J = ~q & n.
  - K = q & ~n.
  - So bits that are unchanged give J=K=0, and J and K are never both 1.
- FSM states: IDLE, EXCITE, DONE.
- IDLE:
  - tgt_ready=1; j_out=k_out=0; q holds.
  - On tgt_valid & tgt_ready at an edge: latch tgt_data and tgt_op, clear step_count, go to EXCITE.
  - Exception: for WALK with tgt_data == q, go straight to DONE with step_count=0.
- EXCITE:
  - tgt_ready=0.
  - Desired next n = target for LOAD; n = q+1 mod 2^W for WALK.
  - j_out/k_out are derived from n; each edge updates q through the JK cells and increments step_count.
  - LOAD: exactly one EXCITE cycle, then DONE.
  - WALK: stay in EXCITE until the edge at which q becomes target, then DONE.
  - WALK wraps from all-ones to 0, so the number of steps is (target - q_start) mod 2^W, at most 2^W-1.
- DONE: done=1 for exactly one cycle; tgt_ready=0; j_out=k_out=0; next edge goes to IDLE.
- LOAD timing:
  - Accept at edge k.
  - q=target after edge k+1.
  - done high between edges k+1 and k+2.
  - tgt_ready=1 again after edge k+2.
  - step_count=1, even when target equals q (that edge applies J=K=0).
- tgt_valid while tgt_ready=0 is ignored; the requester must hold the request until it is accepted.
- q never changes outside EXCITE.

Test Plan:
- Reset with rst_n=0 and q driven to a non-zero value → q=0, tgt_ready=1, done=0, step_count=0, all asynchronously before the next clk edge.
- LOAD 4'b1010 from q=0:
  - In the EXCITE cycle: j_out=1010, k_out=0000.
  - Next cycle: q=1010, done=1, step_count=1.
  - tgt_ready returns 2 edges after accept.
- LOAD 4'b0101 from q=1010 → j_out=0101, k_out=1010, q=0101. Check every cycle that j_out & k_out = 0.
- WALK to 4'b0011 from q=1110:
  - q steps 1111, 0000, 0001, 0010, 0011 (wrap).
  - step_count=5; done a single pulse in the cycle after q reaches 0011.
- WALK with target 0011 == q → no EXCITE cycle; done in the cycle after accept; step_count=0; q unchanged.
- Assert rst_n=0 mid-WALK, then hold tgt_valid during busy:
  - Reset → q=0, no done pulse, IDLE.
  - A held request is accepted only once tgt_ready=1.
